// File: rtl/servo_pkg.sv
// servo_pkg: shared timing defaults, width/step derivation helpers and types
// for the servo_pwm_multi RC-servo PWM generator.
package servo_pkg;

   // Default timing: 50 MHz clock, 20 ms frame, 1 ms .. 2 ms pulse
   localparam int unsigned CLK_HZ         = 50_000_000;
   localparam int unsigned DEF_PERIOD_CYC = CLK_HZ / 50;
   localparam int unsigned DEF_MIN_PULSE  = CLK_HZ / 1000;
   localparam int unsigned DEF_MAX_PULSE  = CLK_HZ / 500;
   localparam int unsigned DEF_SLEW_CYC   = 2_000;
   localparam int unsigned DEF_ANGLE_W    = 8;
   localparam int unsigned DEF_N_CH       = 2;

   // Counter/pulse register width for a given frame length
   function automatic int unsigned cnt_w(input int unsigned period);
      return $clog2(period);
   endfunction

   // Cycles per angle LSB, floored, so ANGLE_MAX never exceeds max_p
   function automatic int unsigned step_cyc(input int unsigned min_p,
                                            input int unsigned max_p,
                                            input int unsigned angle_w);
      return (max_p - min_p) / ((32'd1 << angle_w) - 32'd1);
   endfunction

   localparam int unsigned DEF_CNT_W    = cnt_w(DEF_PERIOD_CYC);
   localparam int unsigned DEF_STEP_CYC = step_cyc(DEF_MIN_PULSE, DEF_MAX_PULSE, DEF_ANGLE_W);

   typedef logic [DEF_CNT_W-1:0] pulse_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/servo_ch.sv
// servo_ch: one servo channel. Holds the commanded target and the pulse width
// in force for the current frame, applies the per-frame step toward the target,
// and drives the registered PWM comparator and in-position flag.
module servo_ch
   import servo_pkg::*;
#(
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned ANGLE_W   = DEF_ANGLE_W,
   parameter int unsigned MIN_PULSE = DEF_MIN_PULSE,
   parameter int unsigned MAX_PULSE = DEF_MAX_PULSE,
   parameter int unsigned STEP_LIM  = DEF_SLEW_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_wr,
   input  logic [ANGLE_W-1:0] i_angle,
   input  logic               i_frame_start,
   input  logic               i_run,
   input  logic [CNT_W-1:0]   i_cnt,
   output logic               o_pwm,
   output logic               o_in_pos
);

   localparam int unsigned STEP_CYC = step_cyc(MIN_PULSE, MAX_PULSE, ANGLE_W);

   logic [CNT_W-1:0] r_tgt;
   logic [CNT_W-1:0] r_cur;
   logic [CNT_W-1:0] w_tgt_new;
   logic [CNT_W-1:0] w_cur_next;
   logic [CNT_W-1:0] w_diff;
   logic             r_pwm;
   logic             r_in_pos;

   assign w_tgt_new = CNT_W'(MIN_PULSE + 32'(i_angle) * STEP_CYC);

   // Next frame's pulse width: step toward target, clamped so it never overshoots
   always_comb begin
      w_diff     = '0;
      w_cur_next = r_cur;
      if (r_tgt >= r_cur) begin
         w_diff     = r_tgt - r_cur;
         w_cur_next = (32'(w_diff) > STEP_LIM) ? r_cur + CNT_W'(STEP_LIM) : r_tgt;
      end else begin
         w_diff     = r_cur - r_tgt;
         w_cur_next = (32'(w_diff) > STEP_LIM) ? r_cur - CNT_W'(STEP_LIM) : r_tgt;
      end
   end

   // Target follows accepted commands; current width changes only at frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tgt <= CNT_W'(MIN_PULSE);
         r_cur <= CNT_W'(MIN_PULSE);
      end else begin
         if (i_wr) begin
            r_tgt <= w_tgt_new;
         end
         if (i_frame_start) begin
            r_cur <= w_cur_next;
         end
      end
   end

   // Registered pulse comparator and in-position flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm    <= 1'b0;
         r_in_pos <= 1'b1;
      end else begin
         r_pwm    <= i_run && (i_cnt < r_cur);
         r_in_pos <= (r_cur == r_tgt);
      end
   end

   assign o_pwm    = r_pwm;
   assign o_in_pos = r_in_pos;

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel RC-servo PWM generator with a shared frame
// counter, valid/ready angle command port and per-channel in-position flags.
// Optional per-frame slew limiting is enabled by defining SERVO_SLEW_EN.
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int unsigned N_CH       = DEF_N_CH,
   parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
   parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC,
   parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
   parameter int unsigned MAX_PULSE  = DEF_MAX_PULSE,
   parameter int unsigned SLEW_CYC   = DEF_SLEW_CYC,
   localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int unsigned CNT_W     = cnt_w(PERIOD_CYC)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [CH_W-1:0]    cmd_ch,
   input  logic [ANGLE_W-1:0] cmd_angle,
   output logic [N_CH-1:0]    servo_pwm,
   output logic               frame_tick,
   output logic [N_CH-1:0]    in_pos
);

`ifdef SERVO_SLEW_EN
   localparam int unsigned STEP_LIM = SLEW_CYC;
`else
   // A limit of at least a full frame can never bind: targets apply in one frame
   localparam int unsigned STEP_LIM = (SLEW_CYC > PERIOD_CYC) ? SLEW_CYC : PERIOD_CYC;
`endif

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;
   logic             r_ready;
   logic             w_run;
   logic             w_accept;
   logic [N_CH-1:0]  w_wr;

   // Dropping enable gates the comparators on the very next edge, mid-pulse or not
   assign w_run    = (r_state == ST_RUN) && enable;
   assign w_accept = cmd_valid && r_ready;

   // IDLE/RUN control, frame counter and frame-start tick (cnt==0 in RUN)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_tick  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         r_ready <= 1'b1;
         if (!enable) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
         end else if (r_state == ST_IDLE) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_tick  <= 1'b1;
         end else if (r_cnt == CNT_W'(PERIOD_CYC - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_tick <= 1'b0;
         end
      end
   end

   // Command decode: out-of-range channel numbers match no strobe and are dropped
   always_comb begin
      w_wr = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (w_accept && (32'(cmd_ch) == i)) begin
            w_wr[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      servo_ch #(
         .CNT_W     (CNT_W),
         .ANGLE_W   (ANGLE_W),
         .MIN_PULSE (MIN_PULSE),
         .MAX_PULSE (MAX_PULSE),
         .STEP_LIM  (STEP_LIM)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .i_wr          (w_wr[g]),
         .i_angle       (cmd_angle),
         .i_frame_start (r_tick),
         .i_run         (w_run),
         .i_cnt         (r_cnt),
         .o_pwm         (servo_pwm[g]),
         .o_in_pos      (in_pos[g])
      );
   end

   assign cmd_ready  = r_ready;
   assign frame_tick = r_tick;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed, table-driven bench for servo_pwm_multi using a
// scaled-down frame (200 cycles, pulses 50..110) and three channels so that an
// out-of-range channel number is representable. Honours SERVO_SLEW_EN.
module tb_servo_pwm_multi;

   localparam int unsigned N_CH    = 3;
   localparam int unsigned ANGLE_W = 4;
   localparam int unsigned PERIOD  = 200;
   localparam int unsigned MIN_P   = 50;
   localparam int unsigned MAX_P   = 112;  // step = 62/15 = 4, angle 15 -> 110
   localparam int unsigned SLEW    = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_ch;
   logic [3:0] cmd_angle;
   logic [2:0] servo_pwm;
   logic       frame_tick;
   logic [2:0] in_pos;

   int n_checks = 0;
   int n_errors = 0;
   int exp_w[3];

   typedef struct {
      logic [1:0] ch;
      logic [3:0] ang;
      int         ip_mid;
      int         w0;
      int         w1;
      int         w2;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   servo_pwm_multi #(
      .N_CH       (N_CH),
      .ANGLE_W    (ANGLE_W),
      .PERIOD_CYC (PERIOD),
      .MIN_PULSE  (MIN_P),
      .MAX_PULSE  (MAX_P),
      .SLEW_CYC   (SLEW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ch     (cmd_ch),
      .cmd_angle  (cmd_angle),
      .servo_pwm  (servo_pwm),
      .frame_tick (frame_tick),
      .in_pos     (in_pos)
   );

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic wait_tick(input string name);
      int i = 0;
      while (frame_tick !== 1'b1 && i < int'(3 * PERIOD)) begin
         @(negedge clk);
         i++;
      end
      check(name, int'(frame_tick === 1'b1), 1);
   endtask

   // Starts at the negedge of a frame_tick cycle and ends at the next one.
   // Up to two one-cycle commands are injected at frame offsets inj_a / inj_b.
   task automatic frame(input string tag,
                        input int inj_a, input logic [1:0] ch_a, input logic [3:0] ang_a,
                        input int inj_b, input logic [1:0] ch_b, input logic [3:0] ang_b,
                        input int e0, input int e1, input int e2, input int eip);
      int w0 = 0;
      int w1 = 0;
      int w2 = 0;
      int ticks = 0;
      int tick_at = -1;
      int ip_mid = -1;
      for (int k = 0; k < int'(PERIOD); k++) begin
         if (k == inj_a) begin
            cmd_valid = 1'b1; cmd_ch = ch_a; cmd_angle = ang_a;
         end else if (k == inj_b) begin
            cmd_valid = 1'b1; cmd_ch = ch_b; cmd_angle = ang_b;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
         w0 += int'(servo_pwm[0] === 1'b1);
         w1 += int'(servo_pwm[1] === 1'b1);
         w2 += int'(servo_pwm[2] === 1'b1);
         if (frame_tick === 1'b1) begin
            ticks++;
            tick_at = k + 1;
         end
         if (k == 30) ip_mid = int'(in_pos);
      end
      cmd_valid = 1'b0;
      if (ticks != 1) tick_at = -1;
      check($sformatf("%s_w0", tag), w0, e0);
      check($sformatf("%s_w1", tag), w1, e1);
      check($sformatf("%s_w2", tag), w2, e2);
      check($sformatf("%s_tick", tag), tick_at, int'(PERIOD));
      check($sformatf("%s_inpos", tag), ip_mid, eip);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      // {ch, angle, in_pos mid-frame, next-frame widths ch0..ch2}
      tbl[0] = '{2'd1, 4'd15, 5, 50, 110, 50};
      tbl[1] = '{2'd0, 4'd8,  6, 82, 110, 50};
      tbl[2] = '{2'd2, 4'd0,  7, 82, 110, 50};
      tbl[3] = '{2'd1, 4'd0,  5, 82, 50,  50};
      tbl[4] = '{2'd2, 4'd1,  3, 82, 50,  54};
      tbl[5] = '{2'd0, 4'd15, 6, 110, 50, 54};
      exp_w[0] = 50; exp_w[1] = 50; exp_w[2] = 50;

      rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_angle = '0;
      #12;
      check("rst_pwm",   int'(servo_pwm), 0);
      check("rst_tick",  int'(frame_tick), 0);
      check("rst_ready", int'(cmd_ready), 0);
      check("rst_inpos", int'(in_pos), 7);

      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", int'(cmd_ready), 1);
      repeat (3) @(negedge clk);
      check("idle_pwm",  int'(servo_pwm), 0);
      check("idle_tick", int'(frame_tick), 0);

      enable = 1'b1;
      @(negedge clk);
      wait_tick("first_tick");
      frame("base", -1, 0, 0, -1, 0, 0, 50, 50, 50, 7);

`ifdef SERVO_SLEW_EN
      frame("slew_cmd", 10, 2'd0, 4'd15, -1, 0, 0, 50, 50, 50, 6);
      for (int f = 1; f <= 8; f++) begin
         e = (50 + 8 * f > 110) ? 110 : 50 + 8 * f;
         frame($sformatf("slew_f%0d", f), -1, 0, 0, -1, 0, 0, e, 50, 50, (f == 8) ? 7 : 6);
      end
      exp_w[0] = 110;
`else
      for (int v = 0; v < 6; v++) begin
         frame($sformatf("v%0d_cmd", v), 10, tbl[v].ch, tbl[v].ang, -1, 0, 0,
               exp_w[0], exp_w[1], exp_w[2], tbl[v].ip_mid);
         exp_w[0] = tbl[v].w0; exp_w[1] = tbl[v].w1; exp_w[2] = tbl[v].w2;
         frame($sformatf("v%0d_new", v), -1, 0, 0, -1, 0, 0,
               exp_w[0], exp_w[1], exp_w[2], 7);
      end
      // Two writes to ch0 in one frame: angle 12 (98) then angle 4 (66); last wins
      frame("dbl", 10, 2'd0, 4'd12, 40, 2'd0, 4'd4, 110, 50, 54, 6);
      exp_w[0] = 66;
      frame("dbl_new", -1, 0, 0, -1, 0, 0, 66, 50, 54, 7);
      // Command on the frame-start edge: this frame keeps the old target
      frame("sim", 0, 2'd0, 4'd15, -1, 0, 0, 66, 50, 54, 6);
      exp_w[0] = 110;
      frame("sim_new", -1, 0, 0, -1, 0, 0, 110, 50, 54, 7);
`endif

      // Out-of-range channel: accepted, nothing changes
      frame("bad_ch", 10, 2'd3, 4'd9, -1, 0, 0, exp_w[0], exp_w[1], exp_w[2], 7);
      check("bad_ch_ready", int'(cmd_ready), 1);
      frame("bad_ch_new", -1, 0, 0, -1, 0, 0, exp_w[0], exp_w[1], exp_w[2], 7);

      // Enable dropped mid-pulse at cnt=20, restored 10 cycles later
      repeat (20) @(negedge clk);
      check("pwm_before_drop", int'(servo_pwm), 7);
      enable = 1'b0;
      @(negedge clk);
      check("pwm_after_drop",  int'(servo_pwm), 0);
      check("tick_after_drop", int'(frame_tick), 0);
      repeat (9) @(negedge clk);
      check("pwm_disabled", int'(servo_pwm), 0);
      enable = 1'b1;
      @(negedge clk);
      check("tick_reenable", int'(frame_tick), 1);
      frame("reenable", -1, 0, 0, -1, 0, 0, exp_w[0], exp_w[1], exp_w[2], 7);

      // Reset asserted mid-pulse with a pending target on ch1
      repeat (5) @(negedge clk);
      cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_angle = 4'd15;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("inpos_pre_rst", int'(in_pos), 5);
      check("pwm_pre_rst",   int'(servo_pwm), 7);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm",   int'(servo_pwm), 0);
      check("async_rst_tick",  int'(frame_tick), 0);
      check("async_rst_ready", int'(cmd_ready), 0);
      check("async_rst_inpos", int'(in_pos), 7);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      wait_tick("post_rst_tick");
      frame("post_rst", -1, 0, 0, -1, 0, 0, 50, 50, 50, 7);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
